// File: rtl/demux_32bus_1x8_hs.sv
// Registered 1-to-8 bus distributor with per-destination holding slots.
// A source word is steered into one slot (or all eight when broadcasting);
// each slot then drains to its own consumer over a valid/ready handshake.
module demux_32bus_1x8_hs #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [2:0]       in_sel,
    input  logic             in_bcast,
    output logic [WIDTH-1:0] out0_data,
    output logic [WIDTH-1:0] out1_data,
    output logic [WIDTH-1:0] out2_data,
    output logic [WIDTH-1:0] out3_data,
    output logic [WIDTH-1:0] out4_data,
    output logic [WIDTH-1:0] out5_data,
    output logic [WIDTH-1:0] out6_data,
    output logic [WIDTH-1:0] out7_data,
    output logic [7:0]       out_valid,
    input  logic [7:0]       out_ready,
    output logic             busy
);

    logic [WIDTH-1:0] r_data [8];
    logic [7:0]       r_valid;

    logic [7:0]       w_can;
    logic             w_inReady;
    logic             w_accept;
    logic [7:0]       w_fill;

    // A slot can take a new word when it is empty or being drained this
    // cycle; broadcast needs every slot free so it is never partial.
    always_comb begin
        w_can     = ~r_valid | out_ready;
        w_inReady = in_bcast ? (&w_can) : w_can[in_sel];
        w_accept  = in_valid & w_inReady;
        w_fill    = 8'h00;
        for (int k = 0; k < 8; k++) begin
            w_fill[k] = w_accept & (in_bcast | (in_sel == 3'(k)));
        end
    end

    // Slot registers: fill wins over drain so a simultaneous drain and
    // refill keeps the slot full with no bubble; drained data stays visible.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 8'h00;
            for (int k = 0; k < 8; k++) begin
                r_data[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (w_fill[k]) begin
                    r_data[k]  <= in_data;
                    r_valid[k] <= 1'b1;
                end else if (out_ready[k]) begin
                    r_valid[k] <= 1'b0;
                end
            end
        end
    end

    assign in_ready  = w_inReady;
    assign out_valid = r_valid;
    assign busy      = |r_valid;
    assign out0_data = r_data[0];
    assign out1_data = r_data[1];
    assign out2_data = r_data[2];
    assign out3_data = r_data[3];
    assign out4_data = r_data[4];
    assign out5_data = r_data[5];
    assign out6_data = r_data[6];
    assign out7_data = r_data[7];

endmodule

// File: tb/tb_demux_32bus_1x8_hs.sv
// Bench for demux_32bus_1x8_hs: directed scenarios followed by a randomized
// phase, with a queue-per-destination scoreboard checked by a monitor.
module tb_demux_32bus_1x8_hs;

    logic        clk;
    logic        rst_n;
    logic        inValid;
    logic        inReady;
    logic [31:0] inData;
    logic [2:0]  inSel;
    logic        inBcast;
    logic [31:0] outData [8];
    logic [7:0]  outValid;
    logic [7:0]  outReady;
    logic        busy;

    demux_32bus_1x8_hs #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .in_data   (inData),
        .in_sel    (inSel),
        .in_bcast  (inBcast),
        .out0_data (outData[0]),
        .out1_data (outData[1]),
        .out2_data (outData[2]),
        .out3_data (outData[3]),
        .out4_data (outData[4]),
        .out5_data (outData[5]),
        .out6_data (outData[6]),
        .out7_data (outData[7]),
        .out_valid (outValid),
        .out_ready (outReady),
        .busy      (busy)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: each destination is a queue of words still owed to
    // its consumer; lastData is what that destination should be showing.
    logic [31:0] expQ [8][$];
    logic [31:0] lastData [8];
    logic [7:0]  modelFull;
    logic [7:0]  modelCan;
    bit          modelReady;
    bit          modelAccept;
    bit          lastAccept;
    bit          started;
    int          checks;
    int          fails;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: mid-cycle, compare DUT outputs with the model, then pop any
    // word the consumer takes at the coming edge and decide whether the
    // source word is accepted.
    always @(negedge clk) begin
        if (!started) begin
            modelAccept = 1'b0;
        end else begin
            for (int k = 0; k < 8; k++) begin
                modelFull[k] = (expQ[k].size() != 0);
            end
            modelCan   = ~modelFull | outReady;
            modelReady = inBcast ? (modelCan == 8'hFF) : modelCan[inSel];
            checkOutput("out_valid", {24'h0, outValid}, {24'h0, modelFull});
            checkOutput("busy", {31'h0, busy}, {31'h0, (modelFull != 8'h00)});
            checkOutput("in_ready", {31'h0, inReady}, {31'h0, modelReady});
            for (int k = 0; k < 8; k++) begin
                checkOutput($sformatf("out%0d_data", k), outData[k], lastData[k]);
            end
            modelAccept = rst_n && inValid && modelReady;
            if (!rst_n) begin
                for (int k = 0; k < 8; k++) begin
                    expQ[k].delete();
                    lastData[k] = 32'h0;
                end
            end else begin
                for (int k = 0; k < 8; k++) begin
                    if (modelFull[k] && outReady[k]) begin
                        checkOutput($sformatf("drain%0d", k), outData[k], expQ[k].pop_front());
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input bit v, input logic [31:0] d, input logic [2:0] s,
                                 input bit b, input logic [7:0] r);
        inValid  = v;
        inData   = d;
        inSel    = s;
        inBcast  = b;
        outReady = r;
    endtask

    // One clock cycle: after the monitor has judged the handshake, push the
    // accepted word into the expected queues, then step past the edge.
    task automatic tick();
        @(negedge clk);
        #1;
        lastAccept = modelAccept;
        if (modelAccept) begin
            for (int k = 0; k < 8; k++) begin
                if (inBcast || inSel == 3'(k)) begin
                    expQ[k].push_back(inData);
                    lastData[k] = inData;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    int          acceptCount;
    bit          pendValid;
    logic [31:0] pendData;
    logic [2:0]  pendSel;
    bit          pendBcast;
    int          leftover;

    initial begin
        checks = 0;
        fails = 0;
        started = 1'b0;
        modelAccept = 1'b0;
        for (int k = 0; k < 8; k++) lastData[k] = 32'h0;
        rst_n = 1'b0;
        applyStimulus(1'b1, $urandom, 3'($urandom), 1'b0, 8'($urandom));

        // Reset with arbitrary inputs for two cycles.
        @(posedge clk);
        #1;
        started = 1'b1;
        applyStimulus(1'b1, $urandom, 3'($urandom), 1'b1, 8'($urandom));
        tick();
        checkOutput("rst_out_valid", {24'h0, outValid}, 32'h0);
        checkOutput("rst_busy", {31'h0, busy}, 32'h0);
        for (int k = 0; k < 8; k++) checkOutput("rst_data", outData[k], 32'h0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 32'h0, 3'd0, 1'b0, 8'h00);
        #1;
        checkOutput("rst_in_ready", {31'h0, inReady}, 32'h1);

        // Unicast into a stalled consumer, then drain-and-refill together.
        applyStimulus(1'b1, 32'hDEADBEEF, 3'd3, 1'b0, 8'h00);
        tick();
        checkOutput("uni_valid", {24'h0, outValid}, 32'h08);
        checkOutput("uni_data", outData[3], 32'hDEADBEEF);
        applyStimulus(1'b1, 32'h12345678, 3'd3, 1'b0, 8'h00);
        #1;
        checkOutput("uni_blocked", {31'h0, inReady}, 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("uni_hold", outData[3], 32'hDEADBEEF);
        end
        applyStimulus(1'b1, 32'h12345678, 3'd3, 1'b0, 8'h08);
        #1;
        checkOutput("uni_refill_ready", {31'h0, inReady}, 32'h1);
        tick();
        checkOutput("uni_refill_valid", {24'h0, outValid}, 32'h08);
        checkOutput("uni_refill_data", outData[3], 32'h12345678);
        applyStimulus(1'b0, 32'h0, 3'd3, 1'b0, 8'h08);
        tick();

        // Streaming 1..16 to destination 5 with its consumer always ready.
        acceptCount = 0;
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b1, 32'(i), 3'd5, 1'b0, 8'h20);
            #1;
            if (inReady) acceptCount++;
            tick();
        end
        checkOutput("stream_accepts", 32'(acceptCount), 32'd16);
        applyStimulus(1'b0, 32'h0, 3'd5, 1'b0, 8'h20);
        tick();
        checkOutput("stream_empty", {24'h0, outValid}, 32'h0);

        // Broadcast held off by a full slot 6, then released.
        applyStimulus(1'b1, 32'h00000066, 3'd6, 1'b0, 8'h00);
        tick();
        applyStimulus(1'b1, 32'hA5A5A5A5, 3'd0, 1'b1, 8'h00);
        #1;
        checkOutput("bcast_blocked", {31'h0, inReady}, 32'h0);
        tick();
        tick();
        checkOutput("bcast_no_change", {24'h0, outValid}, 32'h40);
        checkOutput("bcast_slot6", outData[6], 32'h00000066);
        applyStimulus(1'b1, 32'hA5A5A5A5, 3'd0, 1'b1, 8'h40);
        tick();
        checkOutput("bcast_valid", {24'h0, outValid}, 32'hFF);
        for (int k = 0; k < 8; k++) checkOutput("bcast_data", outData[k], 32'hA5A5A5A5);
        applyStimulus(1'b0, 32'h0, 3'd0, 1'b0, 8'hFF);
        tick();

        // Back-to-back accepts to 0, 7, 2 with all consumers stalled.
        applyStimulus(1'b1, 32'h100, 3'd0, 1'b0, 8'h00);
        tick();
        applyStimulus(1'b1, 32'h107, 3'd7, 1'b0, 8'h00);
        tick();
        applyStimulus(1'b1, 32'h102, 3'd2, 1'b0, 8'h00);
        tick();
        applyStimulus(1'b0, 32'h0, 3'd0, 1'b0, 8'h00);
        checkOutput("inter_valid", {24'h0, outValid}, 32'h85);
        checkOutput("inter_busy", {31'h0, busy}, 32'h1);
        checkOutput("inter_d0", outData[0], 32'h100);
        checkOutput("inter_d7", outData[7], 32'h107);
        checkOutput("inter_d2", outData[2], 32'h102);

        // Reset coincident with an accept to slot 1.
        rst_n = 1'b0;
        applyStimulus(1'b1, 32'h0000BAD1, 3'd1, 1'b0, 8'h00);
        tick();
        rst_n = 1'b1;
        applyStimulus(1'b0, 32'h0, 3'd0, 1'b0, 8'h00);
        checkOutput("midrst_valid", {24'h0, outValid}, 32'h0);
        checkOutput("midrst_slot1", outData[1], 32'h0);

        // Randomized traffic; the source holds its word until accepted.
        pendValid = 1'b0;
        pendData = 32'h0;
        pendSel = 3'd0;
        pendBcast = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!pendValid && ($urandom_range(0, 9) < 7)) begin
                pendValid = 1'b1;
                pendData  = $urandom;
                pendSel   = 3'($urandom_range(0, 7));
                pendBcast = ($urandom_range(0, 7) == 0);
            end
            applyStimulus(pendValid, pendData, pendSel, pendBcast, 8'($urandom));
            tick();
            if (lastAccept) pendValid = 1'b0;
        end
        applyStimulus(1'b0, 32'h0, 3'd0, 1'b0, 8'hFF);
        tick();
        tick();
        leftover = 0;
        for (int k = 0; k < 8; k++) leftover += expQ[k].size();
        checkOutput("final_empty", 32'(leftover), 32'h0);
        checkOutput("final_valid", {24'h0, outValid}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/demux_32bus_1x8_hs.md
# demux_32bus_1x8_hs

- Registered 1-to-8 distributor for 32-bit buses: the write-direction counterpart of the 8:1 bus select.
- Takes one source word with a 3-bit destination select and delivers it into one of eight per-destination holding slots. Broadcast mode writes all eight slots at once.
- Each destination drains its slot independently over a valid/ready handshake.
- Sits between the execute/writeback result source and up to eight consumers (register write port, CSR unit, LSU, and so on), which back-pressure it.

## Interface
- `WIDTH`, default 32: data width of the input and of every output bus.
- `clk` input 1: the only clock; all state updates on its rising edge.
- `rst_n` input 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `in_valid` input 1: the source presents a word.
- `in_ready` output 1: the block accepts the word this cycle (combinational).
- `in_data` input WIDTH: source word.
- `in_sel` input 3: destination index 0..7; ignored when `in_bcast`=1.
- `in_bcast` input 1: deliver `in_data` to all eight slots.
- `out0_data` … `out7_data` output WIDTH each: holding-register contents of slot k.
- `out_valid` output 8: bit k is 1 while slot k holds an undelivered word.
- `out_ready` input 8: bit k is 1 when consumer k takes the word this cycle.
- `busy` output 1: OR of `out_valid`.

## Operation
- **Slot state.** Each slot k has a full flag (`out_valid[k]`) and a WIDTH-bit data register. All eight slots are identical.
- **Per-slot availability.** `can_k` = !`out_valid[k]` | `out_ready[k]`. A full slot being drained this cycle can be refilled in the same cycle.
- **`in_ready`.**
  - `in_bcast`=0: `in_ready` = `can_{in_sel}`.
  - `in_bcast`=1: `in_ready` = AND of all `can_k`.
  - `in_ready` depends only on current state, `in_sel`, `in_bcast` and `out_ready`. It never depends on `in_valid`.
- **Accept.** An accept is `in_valid` & `in_ready`.
  - Unicast: slot `in_sel` loads `in_data` and its valid is set to 1.
  - Broadcast: all eight slots load `in_data` and all valids are set to 1.
- **Drain.** `out_valid[k]` & `out_ready[k]` with no fill of slot k in the same cycle clears `out_valid[k]`. The data register holds its last value, and `outk_data` remains visible while valid=0.
- **Drain and fill together.** If slot k is drained and filled in the same cycle, `out_valid[k]` stays 1 and the data register takes the new word. No bubble is inserted.
- **Non-targeted slots.** Slots not targeted by an accept update only through their own drain handshake.
- **Output stability.** While `out_valid[k]`=1 and `out_ready[k]`=0, `outk_data` and `out_valid[k]` are stable.
- **No-accept cycles.** With `in_valid`=0, or with `in_ready`=0, no slot loads. The source must hold `in_data`, `in_sel` and `in_bcast` until it sees `in_ready`=1.
- **Broadcast is all-or-nothing.** No partial broadcast ever occurs.
- **Reset (`rst_n`=0 at a rising edge):**
  - every `out_valid` bit → 0;
  - every data register → 0;
  - `busy` → 0.
  - Reset takes priority over any simultaneous accept or drain.
  - Held words are discarded when reset is asserted mid-operation.
- **`out_ready` on an empty slot.** Ignored; it has no effect.

## Timing
- **Latency.** Accepted at edge N, a word appears on `outk_data` with `out_valid[k]`=1 in the cycle after edge N (1-cycle latency).
- **Throughput.** One word per cycle to a given destination when its consumer holds `out_ready`=1 continuously. One word per cycle overall when accepts are spread across destinations.
- **Combinational paths.** `in_ready` is combinational from `out_ready`, `in_sel` and `in_bcast`. All other outputs are registered.
- **Reset timing.** Reset is synchronous. Outputs change only at a rising edge with `rst_n`=0. The first accept is possible in the cycle after `rst_n` returns to 1.

## Test plan
- **Reset.**
  - Stimulus: drive arbitrary inputs with `rst_n`=0 for 2 cycles.
  - Required: `out_valid`=8'h00, all `outk_data`=0, `busy`=0.
  - Then, with `in_sel`=0 and every slot empty, `in_ready`=1.
- **Unicast with a stalled consumer.**
  - Stimulus: `in_sel`=3, `in_data`=32'hDEADBEEF, `out_ready`=0.
  - Required: next cycle `out_valid`=8'h08 and `out3_data`=DEADBEEF.
  - Then a second word to `in_sel`=3 sees `in_ready`=0 and the slot holds for 5 cycles.
  - Raising `out_ready[3]` accepts the second word in the same cycle, and `out_valid[3]` stays 1.
- **Streaming.**
  - Stimulus: `in_sel`=5, words 1..16 on consecutive cycles, `out_ready[5]`=1 throughout.
  - Required: 16 accepts in 16 cycles, and consumer 5 receives 1..16 in order with no gaps.
- **Broadcast blocked.**
  - Stimulus: slot 6 full with `out_ready[6]`=0; present `in_bcast`=1, `in_data`=32'hA5A5A5A5.
  - Required: `in_ready`=0 and no slot changes.
  - After slot 6 drains, the broadcast is accepted and `out_valid`=8'hFF next cycle, with all `outk_data`=A5A5A5A5.
- **Interleaved destinations.**
  - Stimulus: back-to-back accepts to `in_sel`=0,7,2 with all `out_ready`=0.
  - Required: `out_valid`=8'h85, each slot holds its own word, and `busy`=1.
- **Reset mid-operation.**
  - Stimulus: `out_valid`=8'h85, then `rst_n`=0 for 1 cycle coincident with an accept to slot 1.
  - Required: `out_valid`=8'h00 and slot 1 is not loaded.
